// File: rtl/drv_segment_scan.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Double-buffered digit data commits only at frame start; all outputs registered.
module drv_segment_scan #(
  parameter int p_digits  = 4,
  parameter int p_show    = 50000,
  parameter int p_blank   = 500,
  parameter int p_sel_low = 1
) (
  input  logic                                           i_clk,
  input  logic                                           i_rst_n,
  input  logic                                           i_en,
  input  logic                                           i_wr,
  input  logic [8*p_digits-1:0]                          i_data,
  input  logic [p_digits-1:0]                            i_mask,
  output logic [7:0]                                     o_val,
  output logic [p_digits-1:0]                            o_sel,
  output logic [(p_digits > 1 ? $clog2(p_digits) : 1)-1:0] o_idx,
  output logic                                           o_frame,
  output logic                                           o_pend
);

  localparam int IW   = (p_digits > 1) ? $clog2(p_digits) : 1;
  localparam int MAXC = (p_show > p_blank) ? p_show : p_blank;
  localparam int CW   = $clog2((MAXC > 2) ? MAXC : 2);

  localparam logic [CW-1:0]       SHOW_LAST  = CW'(p_show - 1);
  localparam logic [CW-1:0]       BLANK_LAST = CW'((p_blank > 0) ? p_blank - 1 : 0);
  localparam logic [IW-1:0]       LAST_IDX   = IW'(p_digits - 1);
  localparam logic [p_digits-1:0] SEL_OFF    = (p_sel_low != 0) ? '1 : '0;

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [8*p_digits-1:0] shadow;
  logic [8*p_digits-1:0] active;

  logic                  show_end;
  logic                  blank_end;
  logic                  enter;
  logic                  fstart;
  logic                  commit;
  logic [IW-1:0]         nidx;
  logic [IW-1:0]         tgt;
  logic [IW-1:0]         disp_idx;
  logic [8*p_digits-1:0] view;
  logic [p_digits-1:0]   sel_on;

  // enter = this edge moves into SHOW; view lets digit 0 show freshly committed data.
  always_comb begin
    show_end  = (state == SHOW) && (cnt == SHOW_LAST);
    blank_end = (state == BLANK) && (cnt == BLANK_LAST);
    nidx      = (idx == LAST_IDX) ? '0 : idx + 1'b1;
    enter     = (state == IDLE) || blank_end || (show_end && (p_blank == 0));
    tgt       = (state == IDLE) ? '0 : nidx;
    fstart    = i_en && enter && (tgt == '0);
    commit    = fstart && o_pend;
    view      = commit ? shadow : active;
    disp_idx  = enter ? tgt : idx;
    sel_on    = SEL_OFF;
    sel_on[disp_idx] = (p_sel_low != 0) ? i_mask[disp_idx] : ~i_mask[disp_idx];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shadow  <= '0;
      active  <= '0;
      o_val   <= '0;
      o_sel   <= SEL_OFF;
      o_frame <= 1'b0;
      o_pend  <= 1'b0;
    end else begin
      o_frame <= fstart;
      if (commit) active <= shadow;
      // A write coinciding with a commit keeps pend set for the next frame.
      if (i_wr) begin
        shadow <= i_data;
        o_pend <= 1'b1;
      end else if (commit) begin
        o_pend <= 1'b0;
      end

      if (!i_en) begin
        state <= IDLE;
        cnt   <= '0;
        idx   <= '0;
        o_sel <= SEL_OFF;
        o_val <= '0;
      end else if (enter) begin
        state <= SHOW;
        cnt   <= '0;
        idx   <= tgt;
        o_sel <= sel_on;
        o_val <= view[8*disp_idx +: 8];
      end else if (show_end) begin
        state <= BLANK;
        cnt   <= '0;
        o_sel <= SEL_OFF;
        o_val <= '0;
      end else begin
        cnt <= cnt + 1'b1;
        if (state == SHOW) begin
          o_sel <= sel_on;
          o_val <= view[8*disp_idx +: 8];
        end
      end
    end
  end

  assign o_idx = idx;

endmodule

// File: tb/tb_drv_segment_scan.sv
// Self-checking bench for drv_segment_scan: per-cycle expected select/value/frame/index
// patterns are queued by each scenario and popped against the DUT outputs.
module tb_drv_segment_scan;

  logic        clk = 1'b0;
  logic        rst_n, en, wr;
  logic [31:0] data;
  logic [3:0]  mask;

  logic [7:0]  val, val0;
  logic [3:0]  sel, sel0;
  logic [1:0]  idx, idx0;
  logic        frame, frame0, pend, pend0;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [7:0] val;
    logic       frame;
    logic [1:0] idx;
  } obs_t;

  localparam obs_t IDLE_OBS = '{sel: 4'hF, val: 8'h00, frame: 1'b0, idx: 2'd0};

  localparam logic [31:0] D_OLD = 32'h03020100;
  localparam logic [31:0] D_NEW = 32'h13121110;
  localparam logic [31:0] D_A   = 32'hA3A2A1A0;
  localparam logic [31:0] D_B   = 32'hB3B2B1B0;

  obs_t sb[$];
  obs_t got, exp;

  always #5 clk = ~clk;

  drv_segment_scan #(.p_digits(4), .p_show(4), .p_blank(1), .p_sel_low(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_wr(wr), .i_data(data), .i_mask(mask),
    .o_val(val), .o_sel(sel), .o_idx(idx), .o_frame(frame), .o_pend(pend)
  );

  drv_segment_scan #(.p_digits(4), .p_show(4), .p_blank(0), .p_sel_low(1)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_wr(wr), .i_data(data), .i_mask(mask),
    .o_val(val0), .o_sel(sel0), .o_idx(idx0), .o_frame(frame0), .o_pend(pend0)
  );

  // One frame of the expected display pattern: 4 show clocks per digit, then blank clocks.
  function automatic void push_frame(input logic [31:0] d, input logic [3:0] m, input int blank);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        obs_t o;
        o.sel   = m[k] ? 4'hF : ~(4'b0001 << k);
        o.val   = d[8*k +: 8];
        o.frame = (k == 0) && (c == 0);
        o.idx   = 2'(k);
        sb.push_back(o);
      end
      for (int c = 0; c < blank; c++) begin
        obs_t o;
        o.sel   = 4'hF;
        o.val   = 8'h00;
        o.frame = 1'b0;
        o.idx   = 2'(k);
        sb.push_back(o);
      end
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; wr = 1'b0; data = '0; mask = '0;
    tick; tick;
    sb.push_back(IDLE_OBS);
    got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL reset_state: got %h, want %h", got, exp);
    end
    compared++;
    if (pend !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_pend: got %b, want 0", pend);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      sb.push_back(IDLE_OBS);
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL idle_disabled[%0d]: got %h, want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_scan;
    wr = 1'b1; data = D_OLD;
    tick;
    wr = 1'b0;
    compared++;
    if (pend !== 1'b1) begin
      mismatched++;
      $display("FAIL scan_pend_after_wr: got %b, want 1", pend);
    end
    en = 1'b1;
    push_frame(D_OLD, 4'b0000, 1);
    push_frame(D_OLD, 4'b0000, 1);
    for (int i = 0; i < 40; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL scan[%0d]: got %h, want %h", i, got, exp);
      end
      if (i == 0) begin
        compared++;
        if (pend !== 1'b0) begin
          mismatched++;
          $display("FAIL scan_pend_commit: got %b, want 0", pend);
        end
      end
    end
  endtask

  task automatic test_write_midframe;
    push_frame(D_OLD, 4'b0000, 1);
    push_frame(D_NEW, 4'b0000, 1);
    for (int i = 0; i < 40; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL midframe[%0d]: got %h, want %h", i, got, exp);
      end
      if (i == 10) begin wr = 1'b1; data = D_NEW; end
      if (i == 11) begin
        wr = 1'b0;
        compared++;
        if (pend !== 1'b1) begin
          mismatched++;
          $display("FAIL midframe_pend_set: got %b, want 1", pend);
        end
      end
      if (i == 20) begin
        compared++;
        if (pend !== 1'b0) begin
          mismatched++;
          $display("FAIL midframe_pend_clear: got %b, want 0", pend);
        end
      end
    end
  endtask

  task automatic test_write_at_frame;
    push_frame(D_NEW, 4'b0000, 1);
    push_frame(D_A, 4'b0000, 1);
    push_frame(D_B, 4'b0000, 1);
    for (int i = 0; i < 60; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL at_frame[%0d]: got %h, want %h", i, got, exp);
      end
      if (i == 5)  begin wr = 1'b1; data = D_A; end
      if (i == 6)  wr = 1'b0;
      if (i == 19) begin wr = 1'b1; data = D_B; end
      if (i == 20) begin
        wr = 1'b0;
        compared++;
        if (pend !== 1'b1) begin
          mismatched++;
          $display("FAIL at_frame_pend_kept: got %b, want 1", pend);
        end
      end
      if (i == 40) begin
        compared++;
        if (pend !== 1'b0) begin
          mismatched++;
          $display("FAIL at_frame_pend_clear: got %b, want 0", pend);
        end
      end
    end
  endtask

  task automatic test_mask;
    mask = 4'b0100;
    push_frame(D_B, 4'b0100, 1);
    for (int i = 0; i < 20; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL mask[%0d]: got %h, want %h", i, got, exp);
      end
    end
    mask = 4'b0000;
  endtask

  task automatic test_enable_drop;
    push_frame(D_B, 4'b0000, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL en_pre[%0d]: got %h, want %h", i, got, exp);
      end
    end
    en = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) sb.push_back(IDLE_OBS);
    for (int i = 0; i < 3; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL en_idle[%0d]: got %h, want %h", i, got, exp);
      end
    end
    en = 1'b1;
    push_frame(D_B, 4'b0000, 1);
    for (int i = 0; i < 20; i++) begin
      tick;
      got = {sel, val, frame, idx}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL en_resume[%0d]: got %h, want %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    sb.delete();
    tick;
    wr = 1'b1; data = D_A;
    tick;
    wr = 1'b0;
    compared++;
    if (sel !== 4'b1110 || val !== 8'hB0 || pend !== 1'b1) begin
      mismatched++;
      $display("FAIL areset_pre: got sel=%b val=%h pend=%b, want sel=1110 val=b0 pend=1", sel, val, pend);
    end
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if (sel !== 4'hF || val !== 8'h00 || pend !== 1'b0 || idx !== 2'd0) begin
      mismatched++;
      $display("FAIL areset_now: got sel=%b val=%h pend=%b idx=%0d, want sel=1111 val=00 pend=0 idx=0",
               sel, val, pend, idx);
    end
    en = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_no_blank;
    wr = 1'b1; data = D_OLD;
    tick;
    wr = 1'b0;
    en = 1'b1;
    sb.delete();
    push_frame(D_OLD, 4'b0000, 0);
    push_frame(D_OLD, 4'b0000, 0);
    for (int i = 0; i < 32; i++) begin
      tick;
      got = {sel0, val0, frame0, idx0}; exp = sb.pop_front(); compared++;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL no_blank[%0d]: got %h, want %h", i, got, exp);
      end
      if (i == 0) begin
        compared++;
        if (pend0 !== 1'b0) begin
          mismatched++;
          $display("FAIL no_blank_pend: got %b, want 0", pend0);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_write_midframe;
    test_write_at_frame;
    test_mask;
    test_enable_drop;
    test_async_reset;
    test_no_blank;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
